// File: rtl/camera_input_controller_pkg.sv
// Shared camera types: fixed-point format, pose record, controller FSM states
// and the saturating arithmetic helpers used to step the pose.
package camera_input_controller_pkg;

    localparam int FP_WIDTH = 24;
    localparam int FP_FRAC  = 12;

    typedef logic signed [FP_WIDTH-1:0] fp_t;
    typedef logic signed [FP_WIDTH:0]   fp_wide_t;

    typedef struct packed {
        fp_t               x;
        fp_t               y;
        fp_t               z;
        logic [7:0]        yaw;
        logic signed [7:0] pitch;
    } camera_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_PUBLISH = 2'd2
    } cam_state_t;

    // +1 / -1 / 0 for a pair of opposing buttons; both held cancels out
    function automatic logic signed [1:0] axis_dir(input logic pos_btn, input logic neg_btn);
        logic signed [1:0] dir;
        case ({pos_btn, neg_btn})
            2'b10:   dir = 2'sb01;
            2'b01:   dir = 2'sb11;
            default: dir = 2'sb00;
        endcase
        return dir;
    endfunction

    function automatic fp_wide_t scale_step(input logic signed [1:0] dir, input fp_wide_t step);
        fp_wide_t delta;
        case (dir)
            2'sb01:  delta = step;
            2'sb11:  delta = -step;
            default: delta = '0;
        endcase
        return delta;
    endfunction

    // Sum is formed one bit wider than fp_t so the clamp sees the true result
    function automatic fp_t sat_pos(input fp_t pos, input fp_wide_t delta, input fp_wide_t limit);
        fp_wide_t sum;
        fp_wide_t neg_limit;
        fp_t      res;
        sum       = fp_wide_t'(pos) + delta;
        neg_limit = -limit;
        if (sum > limit) begin
            res = limit[FP_WIDTH-1:0];
        end else if (sum < neg_limit) begin
            res = neg_limit[FP_WIDTH-1:0];
        end else begin
            res = sum[FP_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/camera_input_controller_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the clean level only
// follows the raw button after it has held a new level for DEBOUNCE_CYCLES.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic raw_in,
    output logic clean_out
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             clean_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then count consecutive cycles that disagree with the clean level
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            clean_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw_in;
            sync2_r <= sync1_r;
            if (sync2_r == clean_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_MAX) begin
                clean_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign clean_out = clean_r;

endmodule

// File: rtl/camera_input_controller.sv
// Debounced buttons/switches to camera pose; at most one motion step per frame,
// published to the ray generator through a valid/ready handshake.
module camera_input_controller
    import camera_input_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BASE_STEP       = 32'h0000_0100,
    parameter int ROT_STEP        = 32'd2,
    parameter int POS_LIMIT       = 32'h0004_0000,
    parameter int INIT_Z          = -32'sh0000_3000
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                btnl_in,
    input  logic                btnr_in,
    input  logic                btnu_in,
    input  logic                btnd_in,
    input  logic [3:0]          sw_in,
    input  logic                frame_start_in,
    input  logic                cam_ready_in,
    output logic                cam_valid_out,
    output logic [FP_WIDTH-1:0] cam_x_out,
    output logic [FP_WIDTH-1:0] cam_y_out,
    output logic [FP_WIDTH-1:0] cam_z_out,
    output logic [7:0]          cam_yaw_out,
    output logic [7:0]          cam_pitch_out,
    output logic [3:0]          btn_db_out
);

    localparam fp_wide_t          LIMIT_W   = fp_wide_t'(POS_LIMIT);
    localparam fp_wide_t          BASE_W    = fp_wide_t'(BASE_STEP);
    localparam fp_t               INIT_Z_FP = fp_t'(INIT_Z);
    localparam logic [7:0]        ROT_U8    = 8'(ROT_STEP);
    localparam logic signed [8:0] ROT_S9    = 9'(ROT_STEP);
    localparam logic signed [8:0] PITCH_MAX = 9'sd64;
    localparam logic signed [8:0] PITCH_MIN = -9'sd64;
    localparam camera_t           RESET_POSE = '{x: '0, y: '0, z: INIT_Z_FP, yaw: 8'd0, pitch: 8'sd0};

    logic [3:0]        btn_db_s;
    logic signed [1:0] dir_h_s;
    logic signed [1:0] dir_v_s;
    fp_wide_t          step_s;
    fp_wide_t          delta_h_s;
    fp_wide_t          delta_v_s;
    logic signed [8:0] pitch_base_s;
    logic signed [8:0] pitch_sum_s;
    camera_t           pose_next_s;

    cam_state_t        state_r;
    logic              valid_r;
    camera_t           pose_r;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk_in(clk_in), .rst_in(rst_in), .raw_in(btnl_in), .clean_out(btn_db_s[3]));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk_in(clk_in), .rst_in(rst_in), .raw_in(btnr_in), .clean_out(btn_db_s[2]));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_u (
        .clk_in(clk_in), .rst_in(rst_in), .raw_in(btnu_in), .clean_out(btn_db_s[1]));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
        .clk_in(clk_in), .rst_in(rst_in), .raw_in(btnd_in), .clean_out(btn_db_s[0]));

    assign dir_h_s   = axis_dir(btn_db_s[2], btn_db_s[3]);
    assign dir_v_s   = axis_dir(btn_db_s[1], btn_db_s[0]);
    assign step_s    = BASE_W << sw_in[3:2];
    assign delta_h_s = scale_step(dir_h_s, step_s);
    assign delta_v_s = scale_step(dir_v_s, step_s);

    // Candidate pose for the next APPLY cycle
    always_comb begin
        pose_next_s  = pose_r;
        pitch_base_s = {pose_r.pitch[7], pose_r.pitch};
        pitch_sum_s  = pitch_base_s;
        if (!sw_in[0]) begin
            pose_next_s.x = sat_pos(pose_r.x, delta_h_s, LIMIT_W);
            if (sw_in[1]) begin
                pose_next_s.y = sat_pos(pose_r.y, delta_v_s, LIMIT_W);
            end else begin
                pose_next_s.z = sat_pos(pose_r.z, delta_v_s, LIMIT_W);
            end
        end else begin
            case (dir_h_s)
                2'sb01:  pose_next_s.yaw = pose_r.yaw + ROT_U8;
                2'sb11:  pose_next_s.yaw = pose_r.yaw - ROT_U8;
                default: pose_next_s.yaw = pose_r.yaw;
            endcase
            case (dir_v_s)
                2'sb01:  pitch_sum_s = pitch_base_s + ROT_S9;
                2'sb11:  pitch_sum_s = pitch_base_s - ROT_S9;
                default: pitch_sum_s = pitch_base_s;
            endcase
            if (pitch_sum_s > PITCH_MAX) begin
                pose_next_s.pitch = 8'sd64;
            end else if (pitch_sum_s < PITCH_MIN) begin
                pose_next_s.pitch = -8'sd64;
            end else begin
                pose_next_s.pitch = pitch_sum_s[7:0];
            end
        end
    end

    // Frame FSM; the pose register only changes in APPLY
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_PUBLISH;
            valid_r <= 1'b0;
            pose_r  <= RESET_POSE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_r <= 1'b0;
                    if (frame_start_in) begin
                        state_r <= ST_APPLY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    pose_r  <= pose_next_s;
                    valid_r <= 1'b1;
                    state_r <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    // valid_r is still low on the first cycle out of reset
                    if (valid_r && cam_ready_in) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        valid_r <= 1'b1;
                        state_r <= ST_PUBLISH;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cam_valid_out = valid_r;
    assign cam_x_out     = pose_r.x;
    assign cam_y_out     = pose_r.y;
    assign cam_z_out     = pose_r.z;
    assign cam_yaw_out   = pose_r.yaw;
    assign cam_pitch_out = pose_r.pitch;
    assign btn_db_out    = btn_db_s;

endmodule

// File: tb/tb_camera_input_controller.sv
// Scoreboard bench: an independent integer model predicts each published pose,
// pushes it when the frame is started and compares it at the handshake.
module tb_camera_input_controller;
    import camera_input_controller_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
    logic [3:0]        sw = 4'd0;
    logic              fs = 1'b0;
    logic              ready = 1'b0;
    logic              valid;
    logic signed [23:0] x_o, y_o, z_o;
    logic [7:0]        yaw_o;
    logic signed [7:0] pitch_o;
    logic [3:0]        db_o;

    int      vectors = 0;
    int      miscompares = 0;
    camera_t sb[$];
    camera_t mdl;
    logic [3:0] mbtn = 4'd0;

    camera_input_controller #(.DEBOUNCE_CYCLES(8)) dut (
        .clk_in(clk), .rst_in(rst),
        .btnl_in(btnl), .btnr_in(btnr), .btnu_in(btnu), .btnd_in(btnd),
        .sw_in(sw), .frame_start_in(fs), .cam_ready_in(ready),
        .cam_valid_out(valid),
        .cam_x_out(x_o), .cam_y_out(y_o), .cam_z_out(z_o),
        .cam_yaw_out(yaw_o), .cam_pitch_out(pitch_o), .btn_db_out(db_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic camera_t reset_pose();
        camera_t p;
        p.x = 24'sd0; p.y = 24'sd0; p.z = -24'sh003000; p.yaw = 8'd0; p.pitch = 8'sd0;
        return p;
    endfunction

    function automatic fp_t clampi(input int v);
        int r;
        r = v;
        if (r > 32'sh40000) r = 32'sh40000;
        else if (r < -32'sh40000) r = -32'sh40000;
        return fp_t'(r);
    endfunction

    function automatic camera_t model_step(input camera_t p, input logic [3:0] b, input logic [3:0] s);
        int step, dx, dv, v;
        step = 32'sh100 << s[3:2];
        dx = (b[2] && !b[3]) ? 1 : ((b[3] && !b[2]) ? -1 : 0);
        dv = (b[1] && !b[0]) ? 1 : ((b[0] && !b[1]) ? -1 : 0);
        if (!s[0]) begin
            p.x = clampi(int'(p.x) + dx * step);
            if (s[1]) p.y = clampi(int'(p.y) + dv * step);
            else      p.z = clampi(int'(p.z) + dv * step);
        end else begin
            p.yaw = 8'((int'(p.yaw) + 2 * dx) & 32'd255);
            v = int'(p.pitch) + 2 * dv;
            if (v > 64) v = 64;
            if (v < -64) v = -64;
            p.pitch = 8'(v);
        end
        return p;
    endfunction

    task automatic set_buttons(input logic [3:0] b);
        {btnl, btnr, btnu, btnd} = b;
        mbtn = b;
        repeat (14) tick();
        chk("db_level", db_o, b);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!valid && n < 10) begin
            tick();
            n++;
        end
        chk("valid_seen", valid, 1'b1);
    endtask

    task automatic handshake();
        camera_t e;
        wait_valid();
        if (sb.size() == 0) begin
            chk("sb_underflow", 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            chk("x", x_o, e.x);
            chk("y", y_o, e.y);
            chk("z", z_o, e.z);
            chk("yaw", yaw_o, e.yaw);
            chk("pitch", pitch_o, e.pitch);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("valid_drop", valid, 1'b0);
    endtask

    task automatic start_frame();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        mdl = model_step(mdl, mbtn, sw);
        sb.push_back(mdl);
        chk("lat_apply", valid, 1'b0);
        tick();
        chk("lat_valid", valid, 1'b1);
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        sb.delete();
        mdl = reset_pose();
        sb.push_back(mdl);
        rst = 1'b0;
    endtask

    task automatic measure_rise(input string tag);
        int n = 0;
        while (db_o[2] == 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, 10);
    endtask

    initial begin
        // 1: reset pose is published straight out of reset
        tick();
        apply_reset(3);
        tick();
        chk("rst_valid", valid, 1'b1);
        chk("rst_db", db_o, 4'd0);
        repeat (5) tick();
        chk("valid_hold", valid, 1'b1);
        handshake();

        // 2: bouncing right button never makes it through
        for (int i = 0; i < 10; i++) begin
            btnr = ~btnr;
            repeat (3) tick();
            chk("bounce_db", db_o[2], 1'b0);
        end
        btnr = 1'b1;
        mbtn = 4'b0100;
        measure_rise("db_rise_lat");

        // 3: translate with speed shift 2; extra frame_start in PUBLISH ignored
        sw = 4'b1000;
        start_frame();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        handshake();
        chk("x_step", x_o, 24'h000400);
        repeat (5) tick();
        chk("no_queued", valid, 1'b0);
        chk("x_hold", x_o, 24'h000400);

        // 4: yaw wraps below zero, pitch clamps at +64
        sw = 4'b0001;
        set_buttons(4'b1000);
        start_frame();
        handshake();
        chk("yaw_wrap", yaw_o, 8'd254);
        set_buttons(4'b0010);
        for (int i = 0; i < 40; i++) begin
            start_frame();
            handshake();
        end
        chk("pitch_clamp", pitch_o, 8'd64);

        // 5: x saturates at +POS_LIMIT; opposing buttons freeze the axis
        sw = 4'b1100;
        set_buttons(4'b0100);
        for (int i = 0; i < 600; i++) begin
            start_frame();
            handshake();
            if (x_o[23]) chk("x_negative", x_o[23], 1'b0);
        end
        chk("x_sat", x_o, 24'h040000);
        set_buttons(4'b1100);
        start_frame();
        handshake();
        chk("x_lr_hold", x_o, 24'h040000);

        // 6: reset while a stepped pose is pending
        apply_reset(3);
        tick();
        handshake();
        sw = 4'b1000;
        set_buttons(4'b0100);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        tick();
        chk("pre_rst_valid", valid, 1'b1);
        chk("pre_rst_x", x_o, 24'h000400);
        apply_reset(2);
        chk("db_cleared", db_o, 4'd0);
        measure_rise("db_rerise_lat");
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
